c3lib_strap_capture: RTL and testbench

//  Consumes a vector of metal-programmable tie cells (tie-high/tie-low strap cells) and produces a validated, registered strap word.

---
 rtl/c3lib_strap_pkg.sv | 22 ++
 rtl/c3lib_sat_cnt.sv | 22 ++
 rtl/c3lib_strap_capture.sv | 138 +++++++++++++
 tb/tb_c3lib_strap_capture.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/c3lib_strap_pkg.sv
// Shared types and constants for the strap capture block.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package c3lib_strap_pkg;

  // Capture FSM states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CONFIRM = 2'd2,
    LOCKED  = 2'd3
  } strap_state_e;

  // Width of the confirm-failure counter; saturates at all-ones
  localparam int MISMATCH_W = 4;

  // Counter width able to hold values 0..maxval, never narrower than one bit
  function automatic int cnt_width(input int maxval);
    return (maxval > 1) ? $clog2(maxval + 1) : 1;
  endfunction

endpackage : c3lib_strap_pkg

// File: rtl/c3lib_sat_cnt.sv
// Saturating up-counter with synchronous clear.
// Latency: count visible one clk after inc.
// Backpressure: none; inc is ignored once the counter sits at all-ones.
module c3lib_sat_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // Count up on inc, hold at all-ones, clear wins over inc
  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule : c3lib_sat_cnt

// File: rtl/c3lib_strap_capture.sv
// Captures tie-cell straps after a settle window and N matching samples, with firmware override.
// Latency: reset release to strap_vld is 1+SETTLE_CYCLES+CONFIRM_CNT clks; override lands in one clk.
// Backpressure: none; recap_req outside LOCKED is dropped, ovrd_wr always accepted.
module c3lib_strap_capture
  import c3lib_strap_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int SETTLE_CYCLES = 4,
  parameter int CONFIRM_CNT   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WIDTH-1:0]      strap_in,
  input  logic                  recap_req,
  input  logic                  ovrd_wr,
  input  logic [WIDTH-1:0]      ovrd_val,
  output logic [WIDTH-1:0]      strap_out,
  output logic                  strap_vld,
  output logic                  strap_ovrd,
  output logic [MISMATCH_W-1:0] mismatch_cnt,
  output logic                  busy
);

  // Settle counter only ever holds SETTLE_CYCLES-1 down to 0
  localparam int SW = cnt_width(SETTLE_CYCLES - 1);
  // Match counter counts 1..CONFIRM_CNT
  localparam int MW = cnt_width(CONFIRM_CNT);

  localparam logic [SW-1:0] SETTLE_LD = SW'(SETTLE_CYCLES - 1);
  localparam logic [MW-1:0] MATCH_TGT = MW'(CONFIRM_CNT);

  strap_state_e     state;
  logic [SW-1:0]    settle_cnt;
  logic [MW-1:0]    match_cnt;
  logic [WIDTH-1:0] sample_reg;

  logic             confirm_cmp;
  logic             confirm_miss;
  logic             mm_inc;
  logic             mm_clr;

  // A confirm compare happens only while the match target is not yet reached;
  // the cycle in which it is reached is spent registering the locked word.
  always_comb begin
    confirm_cmp  = 1'b0;
    confirm_miss = 1'b0;
    if (state == CONFIRM && match_cnt != MATCH_TGT) begin
      confirm_cmp  = 1'b1;
      confirm_miss = (strap_in != sample_reg);
    end
  end

  // Override aborts the capture, so a miss in that same cycle is not counted
  always_comb begin
    mm_clr = ~rst_n;
    mm_inc = rst_n & ~ovrd_wr & confirm_cmp & confirm_miss;
  end

  c3lib_sat_cnt #(
    .W (MISMATCH_W)
  ) u_mismatch_cnt (
    .clk (clk),
    .clr (mm_clr),
    .inc (mm_inc),
    .cnt (mismatch_cnt)
  );

  // Capture FSM with registered outputs; override takes priority over every transition
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      settle_cnt <= '0;
      match_cnt  <= '0;
      sample_reg <= '0;
      strap_out  <= '0;
      strap_vld  <= 1'b0;
      strap_ovrd <= 1'b0;
      busy       <= 1'b0;
    end else if (ovrd_wr) begin
      state      <= LOCKED;
      strap_out  <= ovrd_val;
      strap_vld  <= 1'b1;
      strap_ovrd <= 1'b1;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          settle_cnt <= SETTLE_LD;
          state      <= SETTLE;
          busy       <= 1'b1;
        end

        SETTLE: begin
          if (settle_cnt == '0) begin
            sample_reg <= strap_in;
            match_cnt  <= MW'(1);
            state      <= CONFIRM;
          end else begin
            settle_cnt <= settle_cnt - SW'(1);
          end
        end

        CONFIRM: begin
          if (!confirm_cmp) begin
            // Enough consecutive matches: publish the sampled word
            strap_out  <= sample_reg;
            strap_vld  <= 1'b1;
            strap_ovrd <= 1'b0;
            busy       <= 1'b0;
            state      <= LOCKED;
          end else if (confirm_miss) begin
            // Straps still moving: wait out another settle window
            settle_cnt <= SETTLE_LD;
            state      <= SETTLE;
          end else begin
            match_cnt <= match_cnt + MW'(1);
          end
        end

        LOCKED: begin
          // strap_out is left untouched so consumers must qualify with strap_vld
          if (recap_req) begin
            strap_vld  <= 1'b0;
            settle_cnt <= SETTLE_LD;
            busy       <= 1'b1;
            state      <= SETTLE;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule : c3lib_strap_capture

// File: tb/tb_c3lib_strap_capture.sv
// Randomized plus directed bench for c3lib_strap_capture with a queue-based scoreboard.
// Latency: expected outputs are queued one clk ahead of the DUT edge they describe.
// Backpressure: none; every clk produces one expected record.
module tb_c3lib_strap_capture;

  localparam int WIDTH  = 8;
  localparam int SETTLE = 4;
  localparam int CONF   = 2;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] strap_in;
  logic             recap_req;
  logic             ovrd_wr;
  logic [WIDTH-1:0] ovrd_val;
  logic [WIDTH-1:0] strap_out;
  logic             strap_vld;
  logic             strap_ovrd;
  logic [3:0]       mismatch_cnt;
  logic             busy;

  c3lib_strap_capture #(
    .WIDTH         (WIDTH),
    .SETTLE_CYCLES (SETTLE),
    .CONFIRM_CNT   (CONF)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .strap_in     (strap_in),
    .recap_req    (recap_req),
    .ovrd_wr      (ovrd_wr),
    .ovrd_val     (ovrd_val),
    .strap_out    (strap_out),
    .strap_vld    (strap_vld),
    .strap_ovrd   (strap_ovrd),
    .mismatch_cnt (mismatch_cnt),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] out;
    logic             vld;
    logic             ovrd;
    logic [3:0]       mm;
    logic             busy;
    int               cyc;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   ncyc  = 0;

  // Reference model: one capture attempt is a timeline measured in edges since it began.
  // A reset-initiated attempt carries one extra leading edge (the idle step).
  bit               m_locked;
  int               m_off;
  int               m_age;
  logic [WIDTH-1:0] m_sample;
  logic [WIDTH-1:0] m_out;
  logic             m_vld;
  logic             m_ovrd;
  int               m_mm;
  logic             m_busy;

  task automatic check(input string nm, input int cyc, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_edge(input logic r, input logic [WIDTH-1:0] s, input logic rc,
                            input logic ow, input logic [WIDTH-1:0] ov);
    int s0;
    if (!r) begin
      m_locked = 0; m_off = 1; m_age = 0; m_sample = '0;
      m_out = '0; m_vld = 0; m_ovrd = 0; m_mm = 0;
    end else if (ow) begin
      m_out = ov; m_vld = 1; m_ovrd = 1; m_locked = 1;
    end else if (m_locked) begin
      if (rc) begin
        m_vld = 0; m_locked = 0; m_off = 0; m_age = 0;
      end
    end else begin
      m_age++;
      s0 = m_off + SETTLE;
      if (m_age == s0) begin
        m_sample = s;
      end else if (m_age > s0 && m_age < s0 + CONF) begin
        if (s != m_sample) begin
          if (m_mm < 15) m_mm++;
          m_off = 0;
          m_age = 0;
        end
      end else if (m_age == s0 + CONF) begin
        m_out = m_sample; m_vld = 1; m_ovrd = 0; m_locked = 1;
      end
    end
    m_busy = !m_locked && !(m_off == 1 && m_age == 0);
  endtask

  // Drive one clk worth of inputs and queue what the DUT must show after that edge
  task automatic cyc(input logic r, input logic [WIDTH-1:0] s, input logic rc,
                     input logic ow, input logic [WIDTH-1:0] ov);
    exp_t e;
    @(negedge clk);
    rst_n = r; strap_in = s; recap_req = rc; ovrd_wr = ow; ovrd_val = ov;
    model_edge(r, s, rc, ow, ov);
    ncyc++;
    e.out = m_out; e.vld = m_vld; e.ovrd = m_ovrd; e.mm = m_mm[3:0]; e.busy = m_busy; e.cyc = ncyc;
    q.push_back(e);
  endtask

  task automatic hold(input int n, input logic [WIDTH-1:0] s);
    for (int i = 0; i < n; i++) cyc(1'b1, s, 1'b0, 1'b0, '0);
  endtask

  task automatic peek();
    @(posedge clk);
    #2;
  endtask

  // Monitor: compare every presented output against the oldest queued expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("sb_out",  e.cyc, 32'(strap_out),    32'(e.out));
        check("sb_vld",  e.cyc, 32'(strap_vld),    32'(e.vld));
        check("sb_ovrd", e.cyc, 32'(strap_ovrd),   32'(e.ovrd));
        check("sb_mm",   e.cyc, 32'(mismatch_cnt), 32'(e.mm));
        check("sb_busy", e.cyc, 32'(busy),         32'(e.busy));
      end
    end
  end

  initial begin
    logic [WIDTH-1:0] tog;
    logic [WIDTH-1:0] cur;
    logic [WIDTH-1:0] pick [3];
    rst_n = 1'b0; strap_in = '0; recap_req = 1'b0; ovrd_wr = 1'b0; ovrd_val = '0;
    pick[0] = 8'h3C; pick[1] = 8'hC3; pick[2] = 8'h5A;

    // Stable straps lock after seven clks
    cyc(1'b0, 8'hA5, 0, 0, '0);
    cyc(1'b0, 8'hA5, 0, 0, '0);
    peek();
    check("rst_out", ncyc, 32'(strap_out), 32'h0);
    check("rst_vld", ncyc, 32'(strap_vld), 32'h0);
    check("rst_busy", ncyc, 32'(busy), 32'h0);
    hold(6, 8'hA5);
    peek();
    check("t1_vld_c6", ncyc, 32'(strap_vld), 32'h0);
    hold(1, 8'hA5);
    peek();
    check("t1_vld_c7", ncyc, 32'(strap_vld), 32'h1);
    check("t1_out", ncyc, 32'(strap_out), 32'hA5);
    check("t1_ovrd", ncyc, 32'(strap_ovrd), 32'h0);
    check("t1_mm", ncyc, 32'(mismatch_cnt), 32'h0);

    // Flip during the first confirm clk, relock at clk 12
    cyc(1'b0, 8'hA5, 0, 0, '0);
    hold(5, 8'hA5);
    hold(6, 8'hA4);
    peek();
    check("t2_vld_c11", ncyc, 32'(strap_vld), 32'h0);
    check("t2_mm", ncyc, 32'(mismatch_cnt), 32'h1);
    hold(1, 8'hA4);
    peek();
    check("t2_vld_c12", ncyc, 32'(strap_vld), 32'h1);
    check("t2_out", ncyc, 32'(strap_out), 32'hA4);

    // Override while locked
    cyc(1'b0, 8'hA5, 0, 0, '0);
    hold(7, 8'hA5);
    cyc(1'b1, 8'hA5, 0, 1, 8'h3C);
    peek();
    check("t3_out", ncyc, 32'(strap_out), 32'h3C);
    check("t3_vld", ncyc, 32'(strap_vld), 32'h1);
    check("t3_ovrd", ncyc, 32'(strap_ovrd), 32'h1);

    // Re-capture onto new straps
    cyc(1'b1, 8'h0F, 1, 0, '0);
    peek();
    check("t4_vld_r0", ncyc, 32'(strap_vld), 32'h0);
    check("t4_out_hold", ncyc, 32'(strap_out), 32'h3C);
    hold(5, 8'h0F);
    peek();
    check("t4_vld_r5", ncyc, 32'(strap_vld), 32'h0);
    hold(1, 8'h0F);
    peek();
    check("t4_vld_r6", ncyc, 32'(strap_vld), 32'h1);
    check("t4_out", ncyc, 32'(strap_out), 32'h0F);
    check("t4_ovrd", ncyc, 32'(strap_ovrd), 32'h0);

    // Toggling straps never lock and saturate the miss counter
    tog = 8'h55;
    cyc(1'b1, tog, 1, 0, '0);
    for (int i = 0; i < 120; i++) begin
      tog = ~tog;
      cyc(1'b1, tog, 0, 0, '0);
    end
    peek();
    check("t5_mm", ncyc, 32'(mismatch_cnt), 32'hF);
    check("t5_vld", ncyc, 32'(strap_vld), 32'h0);
    check("t5_busy", ncyc, 32'(busy), 32'h1);

    // Override beats recap in the same clk, then reset mid-settle
    cyc(1'b1, tog, 1, 1, 8'h96);
    peek();
    check("t6_out", ncyc, 32'(strap_out), 32'h96);
    check("t6_ovrd", ncyc, 32'(strap_ovrd), 32'h1);
    check("t6_busy", ncyc, 32'(busy), 32'h0);
    cyc(1'b1, 8'h69, 1, 0, '0);
    hold(2, 8'h69);
    cyc(1'b0, 8'h69, 0, 0, '0);
    peek();
    check("t6_rst_out", ncyc, 32'(strap_out), 32'h0);
    check("t6_rst_ovrd", ncyc, 32'(strap_ovrd), 32'h0);
    check("t6_rst_mm", ncyc, 32'(mismatch_cnt), 32'h0);
    hold(7, 8'h69);
    peek();
    check("t6_relock_vld", ncyc, 32'(strap_vld), 32'h1);
    check("t6_relock_out", ncyc, 32'(strap_out), 32'h69);

    // Random traffic checked only by the scoreboard
    cur = pick[0];
    for (int i = 0; i < 2500; i++) begin
      logic r;
      logic rc;
      logic ow;
      if ($urandom_range(7) == 0) cur = pick[$urandom_range(2)];
      r  = ($urandom_range(199) != 0);
      rc = ($urandom_range(14) == 0);
      ow = ($urandom_range(39) == 0);
      cyc(r, cur, rc, ow, WIDTH'($urandom));
    end
    hold(2, cur);
    @(posedge clk);
    #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_c3lib_strap_capture
